l2_line_responder: RTL and testbench

// - Target end of the core's L2 request/response interface: accepts l2req_packet_t from one core under l2req_ready flow control, services it against a private line-addressed backing store, returns one l2rsp_packet_t per request.
// - Serves as the L2/memory model for single-core bring-up and as the per-port leaf behind a future multi-core L2 arbiter.

---
 rtl/l2_line_responder_pkg.sv | 73 +++++++
 rtl/l2_line_responder_fifo.sv | 50 +++++
 rtl/l2_line_responder.sv | 150 +++++++++++++++
 tb/tb_l2_line_responder.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_line_responder_pkg.sv
// Request/response packet formats, op encodings and line geometry shared by the L2 line responder.
// Line merge helper applies a byte mask to a cache line.
package l2_line_responder_pkg;

  localparam int CACHE_LINE_BITS    = 512;
  localparam int CACHE_LINE_BYTES   = CACHE_LINE_BITS / 8;
  localparam int STRANDS_PER_CORE   = 4;
  localparam int STRAND_INDEX_WIDTH = 2;
  localparam int L2_ADDR_W          = 26;
  localparam int L2_CORE_W          = 2;
  localparam int L2_UNIT_W          = 2;
  localparam int L2_WAY_W           = 3;
  localparam int L2_OP_W            = 3;

  typedef logic [L2_OP_W-1:0] l2req_op_t;

  localparam l2req_op_t L2REQ_LOAD        = 3'd0;
  localparam l2req_op_t L2REQ_LOAD_SYNC   = 3'd1;
  localparam l2req_op_t L2REQ_STORE       = 3'd2;
  localparam l2req_op_t L2REQ_STORE_SYNC  = 3'd3;
  localparam l2req_op_t L2REQ_FLUSH       = 3'd4;
  localparam l2req_op_t L2REQ_DINVALIDATE = 3'd5;
  localparam l2req_op_t L2REQ_IINVALIDATE = 3'd6;

  typedef struct packed {
    logic                          valid;
    logic [L2_CORE_W-1:0]          core;
    logic [L2_UNIT_W-1:0]          unit;
    logic [STRAND_INDEX_WIDTH-1:0] strand;
    l2req_op_t                     op;
    logic [L2_WAY_W-1:0]           way;
    logic [L2_ADDR_W-1:0]          address;
    logic [CACHE_LINE_BITS-1:0]    data;
    logic [CACHE_LINE_BYTES-1:0]   mask;
  } l2req_packet_t;

  typedef struct packed {
    logic                          valid;
    logic                          status;
    logic [L2_CORE_W-1:0]          core;
    logic [L2_UNIT_W-1:0]          unit;
    logic [STRAND_INDEX_WIDTH-1:0] strand;
    l2req_op_t                     op;
    logic [L2_WAY_W-1:0]           way;
    logic [L2_ADDR_W-1:0]          address;
    logic [CACHE_LINE_BITS-1:0]    data;
  } l2rsp_packet_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } l2_state_e;

  typedef struct packed {
    logic                 valid;
    logic [L2_ADDR_W-1:0] address;
  } l2_resv_t;

  function automatic logic [CACHE_LINE_BITS-1:0] merge_line(
    input logic [CACHE_LINE_BITS-1:0]  old_line,
    input logic [CACHE_LINE_BITS-1:0]  new_line,
    input logic [CACHE_LINE_BYTES-1:0] mask
  );
    logic [CACHE_LINE_BITS-1:0] res;
    res = old_line;
    for (int b = 0; b < CACHE_LINE_BYTES; b++) begin
      if (mask[b]) res[b*8 +: 8] = new_line[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/l2_line_responder_fifo.sv
// Synchronous request FIFO with occupancy count; read data is the combinational head entry.
// Pushes while full and pops while empty are ignored.
module l2_request_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = store_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) store_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/l2_line_responder.sv
// L2 target leaf: queues core requests, services them against a private line store, one response each.
// Accept->rsp.valid is ACCESS_LATENCY+2 cycles; ready drops when the queue fills; responses are never stalled.
module l2_line_responder
  import l2_line_responder_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int MEM_LINES      = 256,
  parameter int ACCESS_LATENCY = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  l2req_packet_t l2req_packet,
  output logic          l2req_ready,
  output l2rsp_packet_t l2rsp_packet
);

  localparam int REQ_W  = $bits(l2req_packet_t);
  localparam int IDX_W  = $clog2(MEM_LINES);
  localparam int CNT_W  = $clog2(ACCESS_LATENCY + 1);
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACCESS_LATENCY - 1);

  l2_state_e                  state_q;
  logic [CNT_W-1:0]           cnt_q;
  l2req_packet_t              req_q;
  logic                       status_q;
  l2rsp_packet_t              rsp_q;
  logic                       ready_q;
  l2_resv_t                   resv_q [STRANDS_PER_CORE];
  logic [CACHE_LINE_BITS-1:0] mem_q  [MEM_LINES];

  logic                       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [REQ_W-1:0]           fifo_head;
  logic [FCNT_W-1:0]          fifo_count, count_d;
  logic                       ready_d;
  logic [IDX_W-1:0]           idx;
  logic [CACHE_LINE_BITS-1:0] merged_line;
  logic                       leave_access, resv_hit, do_write, status_d;

  l2_request_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (fifo_push),
    .data_i  (l2req_packet),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign fifo_push = l2req_packet.valid && ready_q && !fifo_full;
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty;

  // Ready reflects the occupancy that will exist after this edge.
  always_comb begin
    count_d = fifo_count;
    if (fifo_push && !fifo_pop)      count_d = fifo_count + 1'b1;
    else if (!fifo_push && fifo_pop) count_d = fifo_count - 1'b1;
    ready_d = (count_d < FCNT_W'(FIFO_DEPTH));
  end

  assign idx          = req_q.address[IDX_W-1:0];
  assign merged_line  = merge_line(mem_q[idx], req_q.data, req_q.mask);
  assign leave_access = (state_q == ACCESS) && (cnt_q == '0);
  assign resv_hit     = resv_q[req_q.strand].valid &&
                        (resv_q[req_q.strand].address == req_q.address);

  always_comb begin
    do_write = 1'b0;
    status_d = 1'b1;
    case (req_q.op)
      L2REQ_STORE:      do_write = 1'b1;
      L2REQ_STORE_SYNC: begin
        do_write = resv_hit;
        status_d = resv_hit;
      end
      L2REQ_LOAD, L2REQ_LOAD_SYNC, L2REQ_FLUSH,
      L2REQ_DINVALIDATE, L2REQ_IINVALIDATE: status_d = 1'b1;
      default:          status_d = 1'b0;
    endcase
  end

  // The store is not reset; gating on reset_n drops a write that coincides with reset.
  always_ff @(posedge clk) begin
    if (reset_n && leave_access && do_write) mem_q[idx] <= merged_line;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      req_q    <= '0;
      status_q <= 1'b0;
      rsp_q    <= '0;
      ready_q  <= 1'b0;
      for (int s = 0; s < STRANDS_PER_CORE; s++) resv_q[s] <= '0;
    end else begin
      ready_q <= ready_d;
      rsp_q   <= '0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            req_q   <= l2req_packet_t'(fifo_head);
            cnt_q   <= CNT_INIT;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            status_q <= status_d;
            state_q  <= RESPOND;
            if (do_write) begin
              for (int s = 0; s < STRANDS_PER_CORE; s++) begin
                if (resv_q[s].address == req_q.address) resv_q[s].valid <= 1'b0;
              end
            end
            if (req_q.op == L2REQ_LOAD_SYNC)
              resv_q[req_q.strand] <= '{valid: 1'b1, address: req_q.address};
            if (req_q.op == L2REQ_STORE_SYNC)
              resv_q[req_q.strand].valid <= 1'b0;
          end
        end
        RESPOND: begin
          // Line is read a cycle after the write, so data is the post-write contents.
          rsp_q.valid   <= req_q.valid;
          rsp_q.status  <= status_q;
          rsp_q.core    <= req_q.core;
          rsp_q.unit    <= req_q.unit;
          rsp_q.strand  <= req_q.strand;
          rsp_q.op      <= req_q.op;
          rsp_q.way     <= req_q.way;
          rsp_q.address <= req_q.address;
          rsp_q.data    <= mem_q[idx];
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign l2req_ready  = ready_q;
  assign l2rsp_packet = rsp_q;

endmodule

// File: tb/tb_l2_line_responder.sv
// Randomized and directed bench for l2_line_responder against a line-store/reservation reference model.
module tb_l2_line_responder;
  import l2_line_responder_pkg::*;

  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int LINES = 256;

  logic          clk = 1'b0;
  logic          reset_n;
  l2req_packet_t req;
  logic          ready;
  l2rsp_packet_t rsp;

  always #5 clk = ~clk;

  l2_line_responder #(
    .FIFO_DEPTH     (DEPTH),
    .MEM_LINES      (LINES),
    .ACCESS_LATENCY (LAT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .l2req_packet (req),
    .l2req_ready  (ready),
    .l2rsp_packet (rsp)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  l2rsp_packet_t got_q[$];
  l2rsp_packet_t exp_q[$];
  int            got_cyc[$];

  always @(negedge clk) begin
    if (rsp.valid === 1'b1) begin
      got_q.push_back(rsp);
      got_cyc.push_back(cyc);
    end
  end

  // Reference model state: the line store and per-strand reservations.
  logic [CACHE_LINE_BITS-1:0] mem_m [LINES];
  bit                         rv_m  [STRANDS_PER_CORE];
  logic [L2_ADDR_W-1:0]       ra_m  [STRANDS_PER_CORE];
  logic [CACHE_LINE_BITS-1:0] line_a;

  function automatic logic [CACHE_LINE_BITS-1:0] rand_line();
    logic [CACHE_LINE_BITS-1:0] l;
    for (int i = 0; i < CACHE_LINE_BITS / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic l2req_packet_t mk(input l2req_op_t op, input int strand,
                                       input logic [L2_ADDR_W-1:0] addr,
                                       input logic [CACHE_LINE_BITS-1:0] data,
                                       input logic [CACHE_LINE_BYTES-1:0] mask);
    l2req_packet_t p;
    p         = '0;
    p.valid   = 1'b1;
    p.core    = L2_CORE_W'($urandom);
    p.unit    = L2_UNIT_W'($urandom);
    p.way     = L2_WAY_W'($urandom);
    p.strand  = STRAND_INDEX_WIDTH'(strand);
    p.op      = op;
    p.address = addr;
    p.data    = data;
    p.mask    = mask;
    return p;
  endfunction

  function automatic void store_m(input l2req_packet_t p, input int idx);
    for (int b = 0; b < CACHE_LINE_BYTES; b++)
      if (p.mask[b]) mem_m[idx][b*8 +: 8] = p.data[b*8 +: 8];
    for (int s = 0; s < STRANDS_PER_CORE; s++)
      if (ra_m[s] == p.address) rv_m[s] = 1'b0;
  endfunction

  function automatic l2rsp_packet_t model(input l2req_packet_t p);
    l2rsp_packet_t r;
    int idx;
    idx       = int'(p.address) % LINES;
    r         = '0;
    r.valid   = 1'b1;
    r.status  = 1'b1;
    r.core    = p.core;
    r.unit    = p.unit;
    r.strand  = p.strand;
    r.op      = p.op;
    r.way     = p.way;
    r.address = p.address;
    case (p.op)
      L2REQ_LOAD_SYNC: begin
        rv_m[p.strand] = 1'b1;
        ra_m[p.strand] = p.address;
      end
      L2REQ_STORE: store_m(p, idx);
      L2REQ_STORE_SYNC: begin
        if (rv_m[p.strand] && ra_m[p.strand] == p.address) store_m(p, idx);
        else r.status = 1'b0;
        rv_m[p.strand] = 1'b0;
      end
      L2REQ_LOAD, L2REQ_FLUSH, L2REQ_DINVALIDATE, L2REQ_IINVALIDATE: r.status = 1'b1;
      default: r.status = 1'b0;
    endcase
    r.data = mem_m[idx];
    return r;
  endfunction

  task automatic send(input l2req_packet_t p, output int acc, output bit stalled);
    int waited;
    waited  = 0;
    stalled = 1'b0;
    acc     = -1;
    @(negedge clk);
    req = p;
    req.valid = 1'b1;
    exp_q.push_back(model(p));
    while (ready !== 1'b1 && waited < 200) begin
      stalled = 1'b1;
      waited++;
      @(negedge clk);
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL send_accept: ready=%b after %0d cycles, required 1", ready, waited);
      req.valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 acc = cyc;
    end
  endtask

  task automatic release_req();
    @(negedge clk);
    req = '0;
  endtask

  task automatic wait_rsps(input int n, output bit ok);
    int w;
    w = 0;
    while (got_q.size() < n && w < 4000) begin
      @(negedge clk);
      w++;
    end
    repeat (2 * (LAT + 2)) @(negedge clk);
    ok = (got_q.size() == n);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req     = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b, required 0", ready);
    end
    checks++;
    if (rsp !== '0) begin
      errors++; $display("FAIL reset_rsp: got valid=%b status=%b addr=%h, required all zero", rsp.valid, rsp.status, rsp.address);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset: got %b, required 1", ready);
    end
  endtask

  task automatic test_fill();
    int acc; bit st, ok, n;
    for (int i = 0; i < LINES; i++)
      send(mk(L2REQ_STORE, $urandom_range(0, 3), {L2_ADDR_W'($urandom_range(0, 3)) << 8} | L2_ADDR_W'(i), rand_line(), '1), acc, st);
    release_req();
    n = 1'b0;
    wait_rsps(LINES, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL fill_count: got %0d responses, required %0d", got_q.size(), LINES);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      l2rsp_packet_t g, e;
      g = got_q.pop_front(); e = exp_q.pop_front(); void'(got_cyc.pop_front());
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL fill_rsp: got op=%0d st=%b addr=%h data=%h, required op=%0d st=%b addr=%h data=%h", g.op, g.status, g.address, g.data, e.op, e.status, e.address, e.data);
      end
    end
    got_q.delete(); exp_q.delete(); got_cyc.delete();
  endtask

  task automatic test_load_after_store();
    int acc_s, acc_l; bit st, ok;
    l2rsp_packet_t g, e;
    line_a = rand_line();
    send(mk(L2REQ_STORE, 0, 26'h10, line_a, '1), acc_s, st);
    release_req();
    wait_rsps(1, ok);
    send(mk(L2REQ_LOAD, 0, 26'h10, rand_line(), '0), acc_l, st);
    release_req();
    wait_rsps(2, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL las_count: got %0d responses, required 2", got_q.size());
    end else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g.status !== 1'b1 || g !== e) begin
        errors++; $display("FAIL las_store: got st=%b data=%h, required st=1 data=%h", g.status, g.data, e.data);
      end
      checks++;
      if (got_cyc[0] - acc_s != LAT + 2) begin
        errors++; $display("FAIL las_store_latency: got %0d, required %0d", got_cyc[0] - acc_s, LAT + 2);
      end
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g.data !== line_a || g.status !== 1'b1 || g !== e) begin
        errors++; $display("FAIL las_load: got st=%b data=%h, required st=1 data=%h", g.status, g.data, line_a);
      end
      checks++;
      if (got_cyc[1] - acc_l != LAT + 2) begin
        errors++; $display("FAIL las_load_latency: got %0d, required %0d", got_cyc[1] - acc_l, LAT + 2);
      end
    end
    got_q.delete(); exp_q.delete(); got_cyc.delete();
  endtask

  task automatic test_partial_store();
    int acc; bit st, ok;
    logic [CACHE_LINE_BITS-1:0] d, want;
    l2rsp_packet_t g, e;
    d         = rand_line();
    d[7:0]    = 8'hAB;
    want      = {line_a[CACHE_LINE_BITS-1:8], 8'hAB};
    send(mk(L2REQ_STORE, 1, 26'h10, d, 64'h1), acc, st);
    send(mk(L2REQ_LOAD, 1, 26'h10, rand_line(), '1), acc, st);
    release_req();
    wait_rsps(2, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL partial_count: got %0d responses, required 2", got_q.size());
    end else begin
      void'(got_q.pop_front()); void'(exp_q.pop_front());
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g.data !== want || g !== e) begin
        errors++; $display("FAIL partial_load: got data=%h, required data=%h", g.data, want);
      end
    end
    got_q.delete(); exp_q.delete(); got_cyc.delete();
  endtask

  task automatic test_sync_pair();
    int acc; bit st, ok;
    bit st_exp [4];
    logic [CACHE_LINE_BITS-1:0] b_line;
    l2rsp_packet_t g, e;
    st_exp = '{1'b1, 1'b1, 1'b0, 1'b1};
    b_line = rand_line();
    send(mk(L2REQ_LOAD_SYNC, 2, 26'h20, rand_line(), '0), acc, st);
    send(mk(L2REQ_STORE_SYNC, 2, 26'h20, b_line, '1), acc, st);
    send(mk(L2REQ_STORE_SYNC, 2, 26'h20, rand_line(), '1), acc, st);
    send(mk(L2REQ_LOAD, 2, 26'h20, rand_line(), '0), acc, st);
    release_req();
    wait_rsps(4, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL sync_count: got %0d responses, required 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        g = got_q.pop_front(); e = exp_q.pop_front();
        checks++;
        if (g.status !== st_exp[i] || g !== e) begin
          errors++; $display("FAIL sync_rsp[%0d]: got st=%b data=%h, required st=%b data=%h", i, g.status, g.data, st_exp[i], e.data);
        end
        if (i == 3) begin
          checks++;
          if (g.data !== b_line) begin
            errors++; $display("FAIL sync_final_line: got %h, required %h", g.data, b_line);
          end
        end
      end
    end
    got_q.delete(); exp_q.delete(); got_cyc.delete();
  endtask

  task automatic test_resv_kill();
    int acc; bit st, ok;
    bit st_exp [4];
    logic [CACHE_LINE_BITS-1:0] orig;
    l2rsp_packet_t g, e;
    st_exp = '{1'b1, 1'b1, 1'b0, 1'b1};
    orig   = mem_m[8'h30];
    send(mk(L2REQ_LOAD_SYNC, 1, 26'h30, rand_line(), '0), acc, st);
    send(mk(L2REQ_STORE, 0, 26'h30, rand_line(), '0), acc, st);
    send(mk(L2REQ_STORE_SYNC, 1, 26'h30, rand_line(), '1), acc, st);
    send(mk(L2REQ_LOAD, 1, 26'h30, rand_line(), '0), acc, st);
    release_req();
    wait_rsps(4, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL kill_count: got %0d responses, required 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        g = got_q.pop_front(); e = exp_q.pop_front();
        checks++;
        if (g.status !== st_exp[i] || g.data !== orig || g !== e) begin
          errors++; $display("FAIL kill_rsp[%0d]: got st=%b data=%h, required st=%b data=%h", i, g.status, g.data, st_exp[i], orig);
        end
      end
    end
    got_q.delete(); exp_q.delete(); got_cyc.delete();
  endtask

  task automatic test_backpressure();
    int acc; bit st, ok, any_stall;
    l2rsp_packet_t g, e;
    any_stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send(mk(l2req_op_t'($urandom_range(0, 6)), $urandom_range(0, 3), 26'h40 + L2_ADDR_W'(i), rand_line(), {$urandom, $urandom}), acc, st);
      any_stall |= st;
    end
    release_req();
    wait_rsps(6, ok);
    checks++;
    if (!any_stall) begin
      errors++; $display("FAIL bp_stall: ready stayed high for 6 back-to-back requests, required a stall");
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL bp_count: got %0d responses, required 6", got_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL bp_rsp: got op=%0d st=%b addr=%h, required op=%0d st=%b addr=%h", g.op, g.status, g.address, e.op, e.status, e.address);
      end
    end
    got_q.delete(); exp_q.delete(); got_cyc.delete();
  endtask

  task automatic test_random();
    int acc, n; bit st, ok;
    logic [L2_ADDR_W-1:0] addrs [5];
    l2rsp_packet_t g, e;
    addrs = '{26'h40, 26'h41, 26'h100040, 26'h55, 26'h3FFFF41};
    n = 80;
    for (int i = 0; i < n; i++) begin
      send(mk(l2req_op_t'($urandom_range(0, 7)), $urandom_range(0, 3), addrs[$urandom_range(0, 4)], rand_line(), ($urandom_range(0, 3) == 0) ? '1 : {$urandom, $urandom}), acc, st);
      if ($urandom_range(0, 2) == 0) begin
        release_req();
        repeat ($urandom_range(0, 6)) @(negedge clk);
      end
    end
    release_req();
    wait_rsps(n, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rand_count: got %0d responses, required %0d", got_q.size(), n);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL rand_rsp: got op=%0d st=%b addr=%h data=%h, required op=%0d st=%b addr=%h data=%h", g.op, g.status, g.address, g.data, e.op, e.status, e.address, e.data);
      end
    end
    got_q.delete(); exp_q.delete(); got_cyc.delete();
  endtask

  task automatic test_reset_mid();
    int acc; bit st, ok;
    l2rsp_packet_t g;
    send(mk(L2REQ_LOAD_SYNC, 3, 26'h77, rand_line(), '0), acc, st);
    release_req();
    wait_rsps(1, ok);
    got_q.delete(); exp_q.delete(); got_cyc.delete();
    for (int i = 0; i < 4; i++)
      send(mk(L2REQ_LOAD, $urandom_range(0, 3), 26'h60 + L2_ADDR_W'(i), rand_line(), '0), acc, st);
    @(negedge clk);
    req     = '0;
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset_ready: got %b, required 0", ready);
    end
    reset_n = 1'b1;
    for (int s = 0; s < STRANDS_PER_CORE; s++) rv_m[s] = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL mid_ready_after: got %b, required 1", ready);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (got_q.size() != 0) begin
      errors++; $display("FAIL mid_no_rsp: got %0d responses, required 0", got_q.size());
    end
    got_q.delete(); got_cyc.delete();
    send(mk(L2REQ_STORE_SYNC, 3, 26'h77, rand_line(), '1), acc, st);
    release_req();
    wait_rsps(1, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL mid_sync_count: got %0d responses, required 1", got_q.size());
    end else begin
      g = got_q.pop_front();
      checks++;
      if (g.status !== 1'b0 || g !== exp_q[0]) begin
        errors++; $display("FAIL mid_sync_cleared: got st=%b data=%h, required st=0 data=%h", g.status, g.data, exp_q[0].data);
      end
    end
    got_q.delete(); exp_q.delete(); got_cyc.delete();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_load_after_store();
    test_partial_store();
    test_sync_pair();
    test_resv_kill();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
